// File: rtl/mem_decoder.sv
// Splits one valid/ready bus onto RAM/ROM/IO targets by base/mask match.
// Unmapped or stalled accesses get an error word so the bus never hangs.
module mem_decoder #(
   parameter logic [31:0] S0_BASE   = 32'h0000_0000,
   parameter logic [31:0] S0_MASK   = 32'hFFFF_0000,
   parameter logic [31:0] S1_BASE   = 32'h1000_0000,
   parameter logic [31:0] S1_MASK   = 32'hFFFF_F000,
   parameter logic [31:0] S2_BASE   = 32'h2000_0000,
   parameter logic [31:0] S2_MASK   = 32'hFFFF_FF00,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        s0_valid,
   input  logic        s0_ready,
   output logic [31:0] s0_addr,
   input  logic [31:0] s0_rdata,
   output logic [31:0] s0_wdata,
   output logic [3:0]  s0_wstrb,
   output logic        s1_valid,
   input  logic        s1_ready,
   output logic [31:0] s1_addr,
   input  logic [31:0] s1_rdata,
   output logic [31:0] s1_wdata,
   output logic [3:0]  s1_wstrb,
   output logic        s2_valid,
   input  logic        s2_ready,
   output logic [31:0] s2_addr,
   input  logic [31:0] s2_rdata,
   output logic [31:0] s2_wdata,
   output logic [3:0]  s2_wstrb,
   output logic        fault_valid,
   output logic [31:0] fault_addr,
   output logic [7:0]  fault_count
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);
   localparam bit TMO_EN = (TIMEOUT != 0);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, ERR} state_t;

   state_t state_q, state_d;
   logic [2:0] valid_q, valid_d;
   logic [2:0][31:0] addr_q, addr_d;
   logic [2:0][31:0] wdata_q, wdata_d;
   logic [2:0][3:0] wstrb_q, wstrb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic fault_valid_q, fault_valid_d;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic [7:0] fault_count_q, fault_count_d;

   logic [2:0] hit;
   logic [2:0] ready_v;
   logic [2:0][31:0] rdata_v;
   logic [1:0] cur;
   logic [1:0] sel;
   state_t sel_state;
   logic go_err;
   logic [31:0] err_addr;

   assign hit[0] = (mem_addr & S0_MASK) == S0_BASE;
   assign hit[1] = (mem_addr & S1_MASK) == S1_BASE;
   assign hit[2] = (mem_addr & S2_MASK) == S2_BASE;

   assign ready_v = {s2_ready, s1_ready, s0_ready};
   assign rdata_v = {s2_rdata, s1_rdata, s0_rdata};

   always_comb begin
      sel = 2'd0;
      sel_state = T0;
      if (hit[0]) begin
         sel = 2'd0;
         sel_state = T0;
      end else if (hit[1]) begin
         sel = 2'd1;
         sel_state = T1;
      end else if (hit[2]) begin
         sel = 2'd2;
         sel_state = T2;
      end
   end

   always_comb begin
      cur = 2'd0;
      case (state_q)
         T1:      cur = 2'd1;
         T2:      cur = 2'd2;
         default: cur = 2'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      cnt_d = cnt_q;
      fault_valid_d = 1'b0;
      fault_addr_d = fault_addr_q;
      fault_count_d = fault_count_q;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      go_err = 1'b0;
      err_addr = mem_addr;
      case (state_q)
         IDLE: begin
            if (mem_valid) begin
               if (|hit) begin
                  valid_d[sel] = 1'b1;
                  addr_d[sel] = mem_addr;
                  wdata_d[sel] = mem_wdata;
                  wstrb_d[sel] = mem_wstrb;
                  cnt_d = '0;
                  state_d = sel_state;
               end else begin
                  go_err = 1'b1;
               end
            end
         end
         T0, T1, T2: begin
            mem_ready = ready_v[cur];
            mem_rdata = rdata_v[cur];
            if (ready_v[cur]) begin
               valid_d[cur] = 1'b0;
               state_d = IDLE;
            end else if (TMO_EN && cnt_q == TERM) begin
               valid_d[cur] = 1'b0;
               go_err = 1'b1;
               err_addr = addr_q[cur];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ERR: begin
            mem_ready = 1'b1;
            mem_rdata = ERR_RDATA;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // fault bookkeeping lands with ERR entry so fault_valid marks the ERR cycle
      if (go_err) begin
         state_d = ERR;
         fault_valid_d = 1'b1;
         fault_addr_d = err_addr;
         if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         valid_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         cnt_q <= '0;
         fault_valid_q <= 1'b0;
         fault_addr_q <= '0;
         fault_count_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         cnt_q <= cnt_d;
         fault_valid_q <= fault_valid_d;
         fault_addr_q <= fault_addr_d;
         fault_count_q <= fault_count_d;
      end
   end

   assign s0_valid = valid_q[0];
   assign s1_valid = valid_q[1];
   assign s2_valid = valid_q[2];
   assign s0_addr = addr_q[0];
   assign s1_addr = addr_q[1];
   assign s2_addr = addr_q[2];
   assign s0_wdata = wdata_q[0];
   assign s1_wdata = wdata_q[1];
   assign s2_wdata = wdata_q[2];
   assign s0_wstrb = wstrb_q[0];
   assign s1_wstrb = wstrb_q[1];
   assign s2_wstrb = wstrb_q[2];
   assign fault_valid = fault_valid_q;
   assign fault_addr = fault_addr_q;
   assign fault_count = fault_count_q;

endmodule

// File: tb/tb_mem_decoder.sv
// Randomized bench for mem_decoder against a transaction-level model
// of address decode, completion timing and fault accounting.
module tb_mem_decoder;

   localparam int TMO = 16;
   localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic mem_valid = 1'b0;
   logic mem_ready;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata = '0;
   logic [3:0] mem_wstrb = '0;
   logic [2:0] s_valid;
   logic [2:0] s_ready = '0;
   logic [31:0] s_rdata [3];
   logic [31:0] s_addr [3];
   logic [31:0] s_wdata [3];
   logic [3:0] s_wstrb [3];
   logic fault_valid;
   logic [31:0] fault_addr;
   logic [7:0] fault_count;

   logic [31:0] base [3];
   logic [31:0] mask [3];
   int n_checks = 0;
   int n_fail = 0;
   int m_fcount = 0;
   logic [31:0] m_faddr = '0;

   always #5 clk = ~clk;

   mem_decoder dut (
      .clk(clk), .rstn(rstn),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .s0_valid(s_valid[0]), .s0_ready(s_ready[0]),
      .s0_addr(s_addr[0]), .s0_rdata(s_rdata[0]),
      .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
      .s1_valid(s_valid[1]), .s1_ready(s_ready[1]),
      .s1_addr(s_addr[1]), .s1_rdata(s_rdata[1]),
      .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
      .s2_valid(s_valid[2]), .s2_ready(s_ready[2]),
      .s2_addr(s_addr[2]), .s2_rdata(s_rdata[2]),
      .s2_wdata(s_wdata[2]), .s2_wstrb(s_wstrb[2]),
      .fault_valid(fault_valid), .fault_addr(fault_addr),
      .fault_count(fault_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < 3; i++)
         if ((a & mask[i]) == base[i]) return i;
      return -1;
   endfunction

   // lat: target raises ready in valid cycle lat+1
   task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int lat,
                      input logic [31:0] rd);
      int t;
      int done_c;
      bit err;
      logic [2:0] ev;
      t = decode(a);
      if (t < 0) begin
         done_c = 1;
         err = 1'b1;
      end else if (lat + 1 <= TMO) begin
         done_c = lat + 1;
         err = 1'b0;
      end else begin
         done_c = TMO + 1;
         err = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_valid = 1'b1;
      mem_addr = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      for (int i = 0; i < 3; i++) s_rdata[i] = $urandom;
      if (t >= 0) s_rdata[t] = rd;
      @(posedge clk);
      for (int c = 1; c <= done_c; c++) begin
         #1;
         s_ready = '0;
         if (t >= 0 && !err && c == lat + 1) s_ready[t] = 1'b1;
         @(negedge clk);
         ev = '0;
         if (t >= 0 && c <= (err ? TMO : lat + 1)) ev[t] = 1'b1;
         chk("s_valid", 32'(s_valid), 32'(ev));
         chk("mem_ready", 32'(mem_ready), 32'(c == done_c));
         chk("fault_valid", 32'(fault_valid), 32'(err && c == done_c));
         if (c == done_c) chk("mem_rdata", mem_rdata, err ? ERRW : rd);
         if (c == 1 && t >= 0) begin
            chk("s_addr", s_addr[t], a);
            chk("s_wdata", s_wdata[t], wd);
            chk("s_wstrb", 32'(s_wstrb[t]), 32'(ws));
         end
         @(posedge clk);
      end
      #1;
      mem_valid = 1'b0;
      s_ready = '0;
      if (err) begin
         m_fcount = (m_fcount < 255) ? m_fcount + 1 : 255;
         m_faddr = a;
         if (t >= 0) s_ready[t] = 1'b1;
      end
      @(negedge clk);
      chk("idle_ready", 32'(mem_ready), 32'(0));
      chk("idle_rdata", mem_rdata, 32'h0);
      chk("idle_valid", 32'(s_valid), 32'(0));
      chk("idle_fvalid", 32'(fault_valid), 32'(0));
      chk("fault_count", 32'(fault_count), 32'(m_fcount));
      chk("fault_addr", fault_addr, m_faddr);
      @(posedge clk);
      #1;
      s_ready = '0;
   endtask

   task automatic reset_mid_t0();
      @(posedge clk);
      #1;
      mem_valid = 1'b1;
      mem_addr = 32'h0000_0080;
      mem_wstrb = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      mem_valid = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      s_ready[0] = 1'b1;
      m_fcount = 0;
      m_faddr = '0;
      @(negedge clk);
      chk("rst_s0_valid", 32'(s_valid), 32'(0));
      chk("rst_ready", 32'(mem_ready), 32'(0));
      chk("rst_fvalid", 32'(fault_valid), 32'(0));
      chk("rst_faddr", fault_addr, 32'h0);
      chk("rst_fcount", 32'(fault_count), 32'(0));
      @(posedge clk);
      #1;
      s_ready = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int r;
      logic [31:0] a;
      base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_0000;
      base[1] = 32'h1000_0000; mask[1] = 32'hFFFF_F000;
      base[2] = 32'h2000_0000; mask[2] = 32'hFFFF_FF00;
      for (int i = 0; i < 3; i++) s_rdata[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 32'(s_valid), 32'(0));
      chk("reset_ready", 32'(mem_ready), 32'(0));
      chk("reset_s0_addr", s_addr[0], 32'h0);
      chk("reset_fcount", 32'(fault_count), 32'(0));
      chk("reset_faddr", fault_addr, 32'h0);
      chk("reset_fvalid", 32'(fault_valid), 32'(0));
      rstn = 1'b1;

      txn(32'h0000_0040, 32'h0, 4'h0, 0, 32'h1234_5678);
      txn(32'h2000_0010, 32'hCAFE_F00D, 4'b0011, 3, 32'h0);
      txn(32'h3000_0000, 32'h0, 4'h0, 0, 32'h0);
      txn(32'h1000_0004, 32'h0, 4'h0, 1000, 32'h0);
      txn(32'h2000_00FC, 32'h0, 4'h0, TMO - 1, 32'h5555_AAAA);
      txn(32'h2000_00F0, 32'h0, 4'h0, TMO, 32'h0);

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 3);
         if (r < 3) a = base[r] | ($urandom & ~mask[r]);
         else a = $urandom;
         txn(a, $urandom, 4'($urandom), $urandom_range(0, TMO + 4), $urandom);
      end

      reset_mid_t0();
      txn(32'h0000_1000, 32'h0, 4'h0, 1, 32'h0BAD_F00D);

      for (int n = 0; n < 300; n++)
         txn(32'h3000_0000 + 32'(n * 4), 32'h0, 4'h0, 0, 32'h0);
      chk("fault_sat", 32'(fault_count), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_decoder.md
Name: mem_decoder

Overview:
- Address decoder and router for the valid/ready memory bus; the split-side counterpart of the two-to-one arbiter.
- Takes one upstream bus from a CPU or arbiter and forwards each transaction to one of three downstream targets (RAM, ROM, IO) using base/mask address matching.
- Answers unmapped addresses and timed-out targets itself with an error word, so the bus never hangs.

Parameters:
S0_BASE, 32'h0000_0000, target 0 base address
S0_MASK, 32'hFFFF_0000, target 0 match mask
S1_BASE, 32'h1000_0000, target 1 base address
S1_MASK, 32'hFFFF_F000, target 1 match mask
S2_BASE, 32'h2000_0000, target 2 base address
S2_MASK, 32'hFFFF_FF00, target 2 match mask
TIMEOUT, 16, maximum cycles a target may hold a request without ready; 0 disables the timeout
ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error response

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
mem_valid  in  1  upstream request valid
mem_ready  out  1  upstream completion strobe
mem_addr  in  32  upstream byte address
mem_rdata  out  32  upstream read data
mem_wdata  in  32  upstream write data
mem_wstrb  in  4  upstream byte strobes; 0 means read
sN_valid  out  1  target N request (N=0,1,2), registered
sN_ready  in  1  target N completion
sN_addr  out  32  target N address, registered
sN_rdata  in  32  target N read data
sN_wdata  out  32  target N write data, registered
sN_wstrb  out  4  target N strobes, registered
fault_valid  out  1  one-cycle pulse on every error response
fault_addr  out  32  address of the most recent fault
fault_count  out  8  saturating fault counter

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk.
  - While rstn=0 at a clk edge: state<=IDLE, all sN_valid<=0, sN_addr/wdata/wstrb<=0, fault_valid<=0, fault_addr<=0, fault_count<=0, timeout counter<=0.
  - Reset mid-transaction abandons it. The target sees valid drop and any late sN_ready is ignored.
- States: IDLE, T0, T1, T2, ERR.
- Decode (combinational on mem_addr): hit N = ((mem_addr & SN_MASK) == SN_BASE). Priority is S0 > S1 > S2 when regions overlap.
- IDLE:
  - If mem_valid and a target hits: latch addr/wdata/wstrb into that target's outputs, set sN_valid<=1, clear the counter, go to TN.
  - If mem_valid and nothing hits: go to ERR and set fault_addr<=mem_addr.
  - Otherwise stay in IDLE. mem_ready=0 in IDLE.
- TN:
  - mem_ready = sN_ready (combinational). mem_rdata = sN_rdata.
  - On sN_ready: sN_valid<=0, go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: sN_valid<=0, fault_addr<=sN_addr, go to ERR.
  - Else increment the counter.
  - Unselected targets always see valid=0.
- ERR:
  - Lasts exactly one cycle. mem_ready=1, mem_rdata=ERR_RDATA, and any write is discarded.
  - fault_valid=1 in this cycle (registered, so it coincides with the ERR state).
  - fault_count increments and saturates at 255. Then go to IDLE.
- mem_rdata is 0 in IDLE. It is only meaningful while mem_ready=1.
- Latency:
  - Request at edge k leaves IDLE. sN_valid is high from cycle k+1.
  - A target answering in its first valid cycle completes upstream at cycle k+1, giving 2 cycles per transaction.
  - Unmapped access: mem_ready at cycle k+1.
  - Timeout: mem_ready at cycle k+1+TIMEOUT.
- Back-to-back: the upstream may present a new request the cycle after mem_ready. It is sampled in IDLE, so there is one idle cycle between downstream transactions.
- A target ready arriving in the same cycle as the timeout terminal count wins: normal completion, no fault.
- Downstream outputs hold their values while valid is high and are don't-care after completion. They keep their last values; they are not cleared.

Test Plan:
1. Read 0x0000_0040, s0 ready on its first valid cycle with rdata 0x1234_5678 -> s0_valid high for 1 cycle, s0_addr=0x40, s0_wstrb=0, mem_ready at request+1 with rdata 0x1234_5678, s1/s2 valid stay 0.
2. Write 0x2000_0010, wdata 0xCAFE_F00D, wstrb 4'b0011; s2 ready after 3 cycles -> s2_wdata=0xCAFE_F00D, s2_wstrb=0011, mem_ready a single pulse 4 cycles after the request.
3. Read 0x3000_0000 (unmapped) -> mem_ready and fault_valid at request+1, mem_rdata=0xDEAD_BEEF, fault_addr=0x3000_0000, fault_count=1, no sN_valid asserted.
4. Read 0x1000_0004 with s1 never ready, TIMEOUT=16 -> s1_valid high for 16 cycles then low, ERR cycle with rdata 0xDEAD_BEEF; a later stray s1_ready produces no mem_ready.
5. s2 ready in exactly the 16th valid cycle -> normal completion with s2 data, fault_count unchanged.
6. rstn=0 for one cycle while in T0 -> s0_valid=0 and state IDLE the next cycle, fault outputs 0; 300 unmapped accesses afterwards -> fault_count saturates at 255.
